sr_flag_rr_arbiter: RTL and testbench
=====================================

// Module: sr_flag_rr_arbiter
// PURPOSE
//  Round-robin arbiter that shares one external SR flip-flop used as a "resource busy" flag between NREQ requesters.
//  Sequences the flop: drives s to claim, r to free, and uses q feedback to confirm each transition before granting or re-arbitrating.
//  Sits between requester logic and the SR flag flop, which has registered q and is reset-able by its own port.
// PARAMETERS
//  NREQ      4    number of requesters (2..8)
//  IDW       2    owner index width, >= clog2(NREQ)
//  HOLD_MAX  16   max OWN cycles before forced release (used only with ARB_TIMEOUT_EN)
// PORTS
//  clk      in   1     rising-edge clock
//  reset    in   1     synchronous, active-low reset
//  req      in   NREQ  request vector, level; sampled only in IDLE
//  rel      in   NREQ  release vector; only rel[owner] is honoured, in OWN
//  q        in   1     feedback from the SR flag flop
//  s        out  1     set drive to the SR flop
//  r        out  1     reset drive to the SR flop
//  gnt      out  NREQ  one-hot grant, high only in OWN
//  owner    out  IDW   index of current/last granted requester
//  busy     out  1     high in any state other than IDLE
//  timeout  out  1     one-cycle pulse on forced release
// BEHAVIOUR
//  - Reset (reset==0 at posedge): state=IDLE, ptr=0, owner=0, cnt=0, gnt=0, s=0, r=0, busy=0, timeout=0.
//  - FSM states: IDLE, SET, OWN, CLR. Moore outputs: s=(state==SET), r=(state==CLR), gnt=onehot(owner) iff OWN.
//  - s and r are never high in the same cycle; s=r=0 in IDLE and OWN.
//  - IDLE: if q==1 (stale flag), go to CLR with no grant. Else if |req, pick the first set bit scanning ptr, ptr+1, ... modulo NREQ;
//    latch owner, go to SET. Else stay in IDLE.
//  - SET: hold s=1 until q==1 is sampled, then go to OWN with cnt=0.
//  - OWN: gnt[owner]=1. If rel[owner], go to CLR and set ptr=(owner+1) mod NREQ. Other rel/req bits are ignored.
//  - CLR: hold r=1 until q==0 is sampled, then go to IDLE.
//  - Latency with a registered SR flop: req high at edge n in IDLE -> s at n+1 -> q at n+2 -> gnt high after edge n+3.
//    From rel at edge m to IDLE: IDLE is reached after edge m+3.
//  - Back-to-back: the earliest next grant is one IDLE cycle after CLR exits. Round robin guarantees no requester waits
//    more than NREQ-1 grants.
//  - Owner dropping req while in OWN has no effect; only rel frees the resource.
//  - Reset mid-operation returns to IDLE immediately. If q is still 1, the IDLE rule forces CLR before any new grant.
//  - owner holds its value after CLR (last owner); ptr wraps NREQ-1 -> 0.
// CONFIGURATION
//  ARB_TIMEOUT_EN defined:
//   - cnt (clog2(HOLD_MAX) bits) increments each OWN cycle.
//   - If cnt==HOLD_MAX-1 and rel[owner]==0: go to CLR, pulse timeout for exactly one cycle (the cycle CLR is entered),
//     and advance ptr as on release.
//   - rel[owner] on that same cycle wins: normal release, no timeout pulse.
//  ARB_TIMEOUT_EN undefined: no counter; OWN persists until rel[owner]; timeout tied to 0.
// TESTING
//  1. Reset with q=0, req=0 -> IDLE; s=r=gnt=busy=0; owner=0.
//  2. req=4'b0100 at edge n -> s=1 at n+1, q=1 at n+2, gnt=4'b0100 and owner=2 after n+3; rel=4'b0100 -> r pulse, IDLE.
//  3. req=4'b1111 held, each owner releases after 2 OWN cycles -> grant order 0,1,2,3,0; s&r never both 1.
//  4. ARB_TIMEOUT_EN, HOLD_MAX=16, owner never releases -> after 16 OWN cycles: CLR, timeout=1 for one cycle, ptr advances.
//     Repeat with rel on cycle 16 -> no timeout.
//  5. Reset asserted in OWN with q=1, then released -> IDLE, then CLR (r=1) until q=0; no gnt before q==0.
//  6. rel=4'b0001 while owner=2 -> ignored, gnt stays 4'b0100.

Source files
------------

// File: rtl/sr_flag_rr_arbiter_if.sv
// Requester/flag-flop bundle for sr_flag_rr_arbiter.
// The arbiter connects through the slave modport; the requester and SR-flop side uses master.
interface sr_flag_rr_arbiter_if #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 2
);
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] rel;
    logic            q;
    logic            s;
    logic            r;
    logic [NREQ-1:0] gnt;
    logic [IDW-1:0]  owner;
    logic            busy;
    logic            timeout;

    modport master (
        output req, rel, q,
        input  s, r, gnt, owner, busy, timeout
    );

    modport slave (
        input  req, rel, q,
        output s, r, gnt, owner, busy, timeout
    );
endinterface

// File: rtl/sr_flag_rr_arbiter.sv
// Round-robin arbiter sharing one external SR "busy" flag flop between NREQ requesters.
// Define ARB_TIMEOUT_EN to force release after HOLD_MAX owned cycles (pulses timeout).
module sr_flag_rr_arbiter #(
    parameter int unsigned NREQ     = 4,
    parameter int unsigned IDW      = 2,
    parameter int unsigned HOLD_MAX = 16
) (
    input logic                 clk_i,
    input logic                 reset_ni,
    sr_flag_rr_arbiter_if.slave bus_io
);

    typedef enum logic [1:0] {StIdle, StSet, StOwn, StClr} state_e;

    localparam bit ParamsOk = (NREQ >= 2) && (NREQ <= 8) && (IDW >= $clog2(NREQ)) &&
                              (HOLD_MAX >= 1);
    localparam logic [NREQ-1:0] GntOne = NREQ'(1);

    if (!ParamsOk) begin : g_bad_params
    end

    state_e          state_q, state_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [IDW-1:0]  owner_q, owner_d;
    logic            timeout_d;
    logic            s_q, r_q, busy_q, timeout_q;
    logic [NREQ-1:0] gnt_q;
    logic            pick_found;
    logic [IDW-1:0]  pick_idx;
    logic [IDW-1:0]  next_ptr;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned CntW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
    logic [CntW-1:0] cnt_q, cnt_d;
`endif

    // First requester at or after ptr, wrapping modulo NREQ.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!pick_found && bus_io.req[(int'(ptr_q) + i) % NREQ]) begin
                pick_found = 1'b1;
                pick_idx   = IDW'((int'(ptr_q) + i) % NREQ);
            end
        end
    end

    assign next_ptr = (owner_q == IDW'(NREQ - 1)) ? '0 : owner_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        timeout_d = 1'b0;
`ifdef ARB_TIMEOUT_EN
        cnt_d     = cnt_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (bus_io.q) begin
                    state_d = StClr;
                end else if (pick_found) begin
                    owner_d = pick_idx;
                    state_d = StSet;
                end
            end
            StSet: begin
                if (bus_io.q) begin
                    state_d = StOwn;
`ifdef ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            StOwn: begin
                if (bus_io.rel[owner_q]) begin
                    state_d = StClr;
                    ptr_d   = next_ptr;
`ifdef ARB_TIMEOUT_EN
                end else if (cnt_q == CntW'(HOLD_MAX - 1)) begin
                    state_d   = StClr;
                    ptr_d     = next_ptr;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            StClr: begin
                if (!bus_io.q) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs are registered from the next state so they stay Moore and glitch-free.
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q   <= StIdle;
            ptr_q     <= '0;
            owner_q   <= '0;
            s_q       <= 1'b0;
            r_q       <= 1'b0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
            gnt_q     <= '0;
`ifdef ARB_TIMEOUT_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            s_q       <= (state_d == StSet);
            r_q       <= (state_d == StClr);
            busy_q    <= (state_d != StIdle);
            timeout_q <= timeout_d;
            gnt_q     <= (state_d == StOwn) ? (GntOne << owner_d) : '0;
`ifdef ARB_TIMEOUT_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    assign bus_io.s       = s_q;
    assign bus_io.r       = r_q;
    assign bus_io.gnt     = gnt_q;
    assign bus_io.owner   = owner_q;
    assign bus_io.busy    = busy_q;
    assign bus_io.timeout = timeout_q;

endmodule

// File: tb/tb_sr_flag_rr_arbiter.sv
// Self-checking bench for sr_flag_rr_arbiter with a registered SR flag flop model.
// Timeout scenarios run only when ARB_TIMEOUT_EN is defined.
module tb_sr_flag_rr_arbiter;
    localparam int unsigned NREQ     = 4;
    localparam int unsigned IDW      = 2;
    localparam int unsigned HOLD_MAX = 16;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic flop_rst_n = 1'b0;
    logic flag_q;
    int   n_cmp = 0;
    int   n_fail = 0;
    int   exp_q[$];

    sr_flag_rr_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

    sr_flag_rr_arbiter #(
        .NREQ    (NREQ),
        .IDW     (IDW),
        .HOLD_MAX(HOLD_MAX)
    ) dut (
        .clk_i   (clk),
        .reset_ni(reset_n),
        .bus_io  (bus)
    );

    always #5 clk = ~clk;

    // External SR flag flop: registered q, own reset, set has priority.
    always @(posedge clk) begin
        if (!flop_rst_n)  flag_q <= 1'b0;
        else if (bus.s)   flag_q <= 1'b1;
        else if (bus.r)   flag_q <= 1'b0;
    end
    assign bus.q = flag_q;

    task automatic test_reset();
        bus.req = '0;
        bus.rel = '0;
        reset_n = 1'b0;
        flop_rst_n = 1'b0;
        repeat (2) @(negedge clk);
        flop_rst_n = 1'b1;
        n_cmp += 6;
        if (bus.s !== 1'b0) begin n_fail++; $display("FAIL reset_s got %b want 0", bus.s); end
        if (bus.r !== 1'b0) begin n_fail++; $display("FAIL reset_r got %b want 0", bus.r); end
        if (bus.gnt !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt got %b want 0000", bus.gnt); end
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        if (bus.owner !== 2'd0) begin n_fail++; $display("FAIL reset_owner got %0d want 0", bus.owner); end
        if (bus.timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout got %b want 0", bus.timeout); end
        reset_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy got %b want 0", bus.busy); end
    endtask

    task automatic test_single_grant();
        int exp;
        bus.req = 4'b0100;
        exp_q.push_back(2);
        @(negedge clk);
        n_cmp += 2;
        if (bus.s !== 1'b1) begin n_fail++; $display("FAIL set_s got %b want 1", bus.s); end
        if (bus.gnt !== 4'b0000) begin n_fail++; $display("FAIL set_gnt got %b want 0000", bus.gnt); end
        bus.req = '0;  // dropping req after it was taken must not matter
        @(negedge clk);
        n_cmp += 2;
        if (bus.q !== 1'b1) begin n_fail++; $display("FAIL flop_q got %b want 1", bus.q); end
        if (bus.gnt !== 4'b0000) begin n_fail++; $display("FAIL early_gnt got %b want 0000", bus.gnt); end
        @(negedge clk);
        exp = exp_q.pop_front();
        n_cmp += 4;
        if (bus.gnt !== 4'b0100) begin n_fail++; $display("FAIL own_gnt got %b want 0100", bus.gnt); end
        if (bus.owner !== IDW'(exp)) begin n_fail++; $display("FAIL own_owner got %0d want %0d", bus.owner, exp); end
        if (bus.s !== 1'b0) begin n_fail++; $display("FAIL own_s got %b want 0", bus.s); end
        if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL own_busy got %b want 1", bus.busy); end
        // Release from a non-owner is ignored.
        bus.rel = 4'b0001;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (bus.gnt !== 4'b0100) begin n_fail++; $display("FAIL foreign_rel got %b want 0100", bus.gnt); end
        bus.rel = 4'b0100;
        @(negedge clk);
        bus.rel = '0;
        n_cmp += 3;
        if (bus.r !== 1'b1) begin n_fail++; $display("FAIL clr_r got %b want 1", bus.r); end
        if (bus.gnt !== 4'b0000) begin n_fail++; $display("FAIL clr_gnt got %b want 0000", bus.gnt); end
        if (bus.s !== 1'b0) begin n_fail++; $display("FAIL clr_s got %b want 0", bus.s); end
        @(negedge clk);
        n_cmp++;
        if (bus.r !== 1'b1) begin n_fail++; $display("FAIL clr_hold_r got %b want 1", bus.r); end
        @(negedge clk);
        n_cmp += 3;
        if (bus.r !== 1'b0) begin n_fail++; $display("FAIL idle_r got %b want 0", bus.r); end
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy2 got %b want 0", bus.busy); end
        if (bus.owner !== 2'd2) begin n_fail++; $display("FAIL last_owner got %0d want 2", bus.owner); end
    endtask

    task automatic test_round_robin();
        int cyc;
        int exp;
        logic [NREQ-1:0] exp_gnt;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        bus.req = 4'b1111;
        for (int k = 0; k < 5; k++) exp_q.push_back(k % NREQ);
        for (int k = 0; k < 5; k++) begin
            cyc = 0;
            while (bus.gnt === '0 && cyc < 20) begin
                @(negedge clk);
                cyc++;
                n_cmp++;
                if (bus.s && bus.r) begin n_fail++; $display("FAIL s_and_r got 1 want 0"); end
            end
            exp = exp_q.pop_front();
            exp_gnt = '0;
            exp_gnt[exp] = 1'b1;
            n_cmp += 2;
            if (cyc >= 20) begin n_fail++; $display("FAIL rr_wait got timeout want grant %0d", exp); end
            if (bus.gnt !== exp_gnt || bus.owner !== IDW'(exp)) begin
                n_fail++;
                $display("FAIL rr_order got gnt=%b owner=%0d want gnt=%b owner=%0d",
                         bus.gnt, bus.owner, exp_gnt, exp);
            end
            @(negedge clk);
            bus.rel = exp_gnt;
            @(negedge clk);
            bus.rel = '0;
            n_cmp++;
            if (bus.gnt !== 4'b0000) begin n_fail++; $display("FAIL rr_release got %b want 0000", bus.gnt); end
        end
        bus.req = '0;
        cyc = 0;
        while (bus.busy !== 1'b0 && cyc < 20) begin @(negedge clk); cyc++; end
        n_cmp++;
        if (cyc >= 20) begin n_fail++; $display("FAIL rr_drain got busy want idle"); end
    endtask

    task automatic test_reset_mid_op();
        int  cyc;
        bit  seen_q0;
        bus.req = 4'b0010;
        cyc = 0;
        while (bus.gnt === '0 && cyc < 20) begin @(negedge clk); cyc++; end
        n_cmp++;
        if (bus.gnt !== 4'b0010) begin n_fail++; $display("FAIL mid_grant got %b want 0010", bus.gnt); end
        bus.req = 4'b1000;
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        n_cmp += 3;
        if (bus.busy !== 1'b0 || bus.gnt !== 4'b0000) begin
            n_fail++;
            $display("FAIL mid_reset got busy=%b gnt=%b want busy=0 gnt=0000", bus.busy, bus.gnt);
        end
        if (bus.q !== 1'b1) begin n_fail++; $display("FAIL mid_stale_q got %b want 1", bus.q); end
        if (bus.owner !== 2'd0) begin n_fail++; $display("FAIL mid_owner got %0d want 0", bus.owner); end
        @(negedge clk);
        n_cmp += 2;
        if (bus.r !== 1'b1) begin n_fail++; $display("FAIL stale_clr_r got %b want 1", bus.r); end
        if (bus.gnt !== 4'b0000) begin n_fail++; $display("FAIL stale_gnt got %b want 0000", bus.gnt); end
        seen_q0 = 1'b0;
        cyc = 0;
        while (bus.gnt === '0 && cyc < 20) begin
            if (bus.q === 1'b0) seen_q0 = 1'b1;
            @(negedge clk);
            cyc++;
        end
        n_cmp += 2;
        if (!seen_q0) begin n_fail++; $display("FAIL stale_order got grant before q=0 want q=0 first"); end
        if (bus.gnt !== 4'b1000) begin n_fail++; $display("FAIL stale_next got %b want 1000", bus.gnt); end
        bus.req = '0;
        bus.rel = 4'b1000;
        @(negedge clk);
        bus.rel = '0;
        repeat (3) @(negedge clk);
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout();
        int cyc;
        int own_cycles;
        bus.req = 4'b0001;
        cyc = 0;
        while (bus.gnt === '0 && cyc < 20) begin @(negedge clk); cyc++; end
        own_cycles = 0;
        while (bus.gnt !== '0 && own_cycles < 40) begin @(negedge clk); own_cycles++; end
        bus.req = 4'b0011;
        n_cmp += 3;
        if (own_cycles != HOLD_MAX) begin n_fail++; $display("FAIL to_own_cycles got %0d want %0d", own_cycles, HOLD_MAX); end
        if (bus.timeout !== 1'b1) begin n_fail++; $display("FAIL to_pulse got %b want 1", bus.timeout); end
        if (bus.r !== 1'b1) begin n_fail++; $display("FAIL to_clr got %b want 1", bus.r); end
        @(negedge clk);
        n_cmp++;
        if (bus.timeout !== 1'b0) begin n_fail++; $display("FAIL to_width got %b want 0", bus.timeout); end
        cyc = 0;
        while (bus.gnt === '0 && cyc < 20) begin @(negedge clk); cyc++; end
        n_cmp++;
        if (bus.owner !== 2'd1) begin n_fail++; $display("FAIL to_ptr got owner %0d want 1", bus.owner); end
        bus.req = '0;
        // Release on the final allowed cycle must beat the timeout.
        repeat (HOLD_MAX - 1) @(negedge clk);
        bus.rel = 4'b0010;
        @(negedge clk);
        bus.rel = '0;
        n_cmp += 2;
        if (bus.timeout !== 1'b0) begin n_fail++; $display("FAIL rel_wins got %b want 0", bus.timeout); end
        if (bus.r !== 1'b1) begin n_fail++; $display("FAIL rel_wins_clr got %b want 1", bus.r); end
        repeat (3) @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_single_grant();
        test_round_robin();
        test_reset_mid_op();
`ifdef ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
